// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read path and the camera write-side packer.
// Holds default panel geometry, SDRAM word pack layout, FSM states and pipeline metadata.
// No ports; imported by lcd_timing_gen and lcd_frame_reader.
package lcd_pkg;

  // Default 800x480 panel geometry (pixel clocks / lines).
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 21;

  localparam int unsigned H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  // Counter / coordinate width.
  localparam int CNT_W = 16;

  // Pack layout of the two 16-bit SDRAM words; bit 15 of each word is unused.
  //   rd1 = {1'b0, G[9:5], B[9:0]}
  //   rd2 = {1'b0, G[4:0], R[9:0]}
  localparam int PK1_G_MSB = 14;
  localparam int PK1_G_LSB = 10;
  localparam int PK1_B_MSB = 9;
  localparam int PK1_B_LSB = 0;
  localparam int PK2_G_MSB = 14;
  localparam int PK2_G_LSB = 10;
  localparam int PK2_R_MSB = 9;
  localparam int PK2_R_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } lcd_state_e;

  // Raster attributes carried alongside each pixel slot through the delay pipeline.
  typedef struct packed {
    logic             de;
    logic             hs_n;
    logic             vs_n;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } pix_meta_t;

  localparam pix_meta_t PIX_META_RST = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, x: '0, y: '0};

endpackage

// File: rtl/lcd_frame_reader_if.sv
// Read-side bus between lcd_frame_reader and the two SDRAM read FIFOs.
// Data arrives one cycle after rd_req; rd_empty qualifies the cycle rd_req is high.
// Ports: rd_req (reader->fifo), rd1_dat/rd2_dat/rd_empty (fifo->reader).
interface lcd_frame_reader_if;
  logic        rd_req;
  logic [15:0] rd1_dat;
  logic [15:0] rd2_dat;
  logic        rd_empty;

  modport master (
    output rd_req,
    input  rd1_dat,
    input  rd2_dat,
    input  rd_empty
  );

  modport slave (
    input  rd_req,
    output rd1_dat,
    output rd2_dat,
    output rd_empty
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster counters plus IDLE/SCAN control; decodes sync and active region from the counters.
// Latency: decode is combinational on the registered counters; frame_start is registered.
// Backpressure: none, the raster free-runs once started and only stops at a frame boundary.
// Ports: iClk, iRst_n, enable (sampled at frame boundary), frame_start, active, hs_n, vs_n, x, y.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             enable,
  output logic             frame_start,
  output logic             active,
  output logic             hs_n,
  output logic             vs_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y
);

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_start_d;
  logic             line_end;
  logic             frame_end;
  logic             scanning;
  logic             h_act;
  logic             v_act;

  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= ST_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_start <= frame_start_d;
    end
  end

  // frame_start is high in the cycle the counters sit at (0,0) of a new frame,
  // well ahead of the first request so the controller can rewind its address.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) begin
          state_d       = ST_SCAN;
          frame_start_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (line_end) begin
          h_cnt_d = '0;
          if (frame_end) begin
            v_cnt_d = '0;
            if (enable) begin
              frame_start_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign scanning = (state_q == ST_SCAN);
  assign h_act    = (h_cnt_q >= H_ACT_START) && (h_cnt_q <= H_ACT_END);
  assign v_act    = (v_cnt_q >= V_ACT_START) && (v_cnt_q <= V_ACT_END);
  assign active   = scanning && h_act && v_act;
  assign hs_n     = !(scanning && (h_cnt_q < H_SYNC_END));
  assign vs_n     = !(scanning && (v_cnt_q < V_SYNC_END));
  // Only meaningful while active; the parent ignores them otherwise.
  assign x        = h_cnt_q - H_ACT_START;
  assign y        = v_cnt_q - V_ACT_START;

endmodule

// File: rtl/lcd_frame_reader.sv
// LCD scan-out: raster timing, FIFO read requests, RGB unpack, aligned panel outputs.
// Latency: counter state at t -> rd_req at t+1, FIFO data at t+2, panel outputs at t+3.
// Backpressure: none; an empty FIFO on a request blanks that pixel and sets sticky oUnderflow.
// Ports: iClk, iRst_n, iEnable, rd_if (master: rd_req / rd1_dat / rd2_dat / rd_empty),
//        oFrameStart, oLCD_R/G/B, oHS, oVS (active low), oDE, oX, oY, oUnderflow.
module lcd_frame_reader
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iEnable,
  lcd_frame_reader_if.master         rd_if,
  output logic                       oFrameStart,
  output logic [7:0]                 oLCD_R,
  output logic [7:0]                 oLCD_G,
  output logic [7:0]                 oLCD_B,
  output logic                       oHS,
  output logic                       oVS,
  output logic                       oDE,
  output logic [15:0]                oX,
  output logic [15:0]                oY,
  output logic                       oUnderflow
);

  logic             tg_active;
  logic             tg_hs_n;
  logic             tg_vs_n;
  logic [CNT_W-1:0] tg_x;
  logic [CNT_W-1:0] tg_y;

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .enable      (iEnable),
    .frame_start (oFrameStart),
    .active      (tg_active),
    .hs_n        (tg_hs_n),
    .vs_n        (tg_vs_n),
    .x           (tg_x),
    .y           (tg_y)
  );

  // s1: request stage (s1.de doubles as the FIFO read request).
  // s2: data stage, FIFO words valid this cycle.
  pix_meta_t s1, s2;
  logic      und2;

  assign rd_if.rd_req = s1.de;

  // Reassemble 10-bit components; the panel takes the top 8 bits of each.
  logic [9:0] r10, g10, b10;
  assign r10 = rd_if.rd2_dat[PK2_R_MSB:PK2_R_LSB];
  assign g10 = {rd_if.rd1_dat[PK1_G_MSB:PK1_G_LSB], rd_if.rd2_dat[PK2_G_MSB:PK2_G_LSB]};
  assign b10 = rd_if.rd1_dat[PK1_B_MSB:PK1_B_LSB];

  logic unused_bits;
  assign unused_bits = ^{r10[1:0], g10[1:0], b10[1:0], rd_if.rd1_dat[15], rd_if.rd2_dat[15]};

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1         <= PIX_META_RST;
      s2         <= PIX_META_RST;
      und2       <= 1'b0;
      oLCD_R     <= '0;
      oLCD_G     <= '0;
      oLCD_B     <= '0;
      oDE        <= 1'b0;
      oHS        <= 1'b1;
      oVS        <= 1'b1;
      oX         <= '0;
      oY         <= '0;
      oUnderflow <= 1'b0;
    end else begin
      s1   <= '{de: tg_active, hs_n: tg_hs_n, vs_n: tg_vs_n, x: tg_x, y: tg_y};
      s2   <= s1;
      // Empty is qualified in the request cycle; the pixel it affects lands two cycles later.
      und2 <= s1.de & rd_if.rd_empty;

      oDE <= s2.de;
      oHS <= s2.hs_n;
      oVS <= s2.vs_n;
      // Coordinates hold the last active pixel through blanking.
      if (s2.de) begin
        oX <= s2.x;
        oY <= s2.y;
      end
      if (s2.de && !und2) begin
        oLCD_R <= r10[9:2];
        oLCD_G <= g10[9:2];
        oLCD_B <= b10[9:2];
      end else begin
        oLCD_R <= '0;
        oLCD_G <= '0;
        oLCD_B <= '0;
      end
      if (s2.de && und2) begin
        oUnderflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader on a reduced raster (15x8 clocks per frame).
module tb_lcd_frame_reader;

  localparam int HA = 8, HFP = 2, HS = 3, HB = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VB = 1;
  localparam int HT = HS + HB + HA + HFP;   // 15
  localparam int VT = VS + VB + VA + VFP;   // 8
  // Pixel (5,2) plays the role of the underflow target on this small raster.
  localparam int INJ_IDX = 2 * HA + 5;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iEnable;
  logic        oFrameStart;
  logic [7:0]  oLCD_R, oLCD_G, oLCD_B;
  logic        oHS, oVS, oDE;
  logic [15:0] oX, oY;
  logic        oUnderflow;

  lcd_frame_reader_if rd_if();

  lcd_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iEnable     (iEnable),
    .rd_if       (rd_if),
    .oFrameStart (oFrameStart),
    .oLCD_R      (oLCD_R),
    .oLCD_G      (oLCD_G),
    .oLCD_B      (oLCD_B),
    .oHS         (oHS),
    .oVS         (oVS),
    .oDE         (oDE),
    .oX          (oX),
    .oY          (oY),
    .oUnderflow  (oUnderflow)
  );

  initial forever #5 iClk = ~iClk;

  int tests = 0;
  int failed = 0;
  logic [56:0] exp_q[$];
  logic inject_en = 1'b0;

  // Monitor statistics, updated on every falling edge.
  int cyc = 0, fs_cnt = 0, req_cnt = 0, de_cnt = 0, hs_low = 0, vs_low = 0;
  int last_fs_cyc = 0, prev_fs_cyc = 0, first_req_cyc = 0, first_de_cyc = 0;
  logic [55:0] first_pix = '0;

  function automatic logic [31:0] word_pair(input int n);
    logic [15:0] a, b;
    if (n == 0) begin
      a = 16'h7FFF;
      b = 16'h03FF;
    end else begin
      a = {1'b0, 15'(n * 613 + 11)};
      b = {1'b0, 15'(n * 2477 + 3)};
    end
    return {a, b};
  endfunction

  // {underflow, R, G, B, X, Y} the panel should show for pixel n.
  function automatic logic [56:0] pix_expect(input logic [15:0] a, input logic [15:0] b,
                                             input logic blank, input logic und, input int n);
    logic [7:0]  r, g, bl;
    logic [15:0] x, y;
    r  = b[9:2];
    g  = {a[14:10], b[14:12]};
    bl = a[9:2];
    if (blank) begin
      r = 8'h00; g = 8'h00; bl = 8'h00;
    end
    x = 16'(n % HA);
    y = 16'(n / HA);
    return {und, r, g, bl, x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge iClk);
      #2;
    end
  endtask

  task automatic wait_fs(input int limit, input string tag);
    int start;
    int k;
    start = fs_cnt;
    k = 0;
    while (fs_cnt == start && k < limit) begin
      tick(1);
      k++;
    end
    tests++;
    assert ((fs_cnt != start) === 1'b1) else begin
      failed++;
      $error("FAIL %s no oFrameStart within %0d cycles (observed count %0d, required > %0d)",
             tag, limit, fs_cnt, start);
    end
  endtask

  // FIFO model: one-cycle read latency; pushes the expected pixel as each word is served.
  initial begin : fifo_model
    logic req_prev, empty_prev, und_model;
    logic [31:0] wp;
    int pix_idx;
    req_prev = 1'b0; empty_prev = 1'b0; und_model = 1'b0; pix_idx = 0;
    rd_if.rd1_dat = '0; rd_if.rd2_dat = '0; rd_if.rd_empty = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      if (!iRst_n) begin
        req_prev = 1'b0; empty_prev = 1'b0; und_model = 1'b0; pix_idx = 0;
        rd_if.rd_empty = 1'b0;
      end else begin
        if (req_prev) begin
          wp = word_pair(pix_idx);
          rd_if.rd1_dat = wp[31:16];
          rd_if.rd2_dat = wp[15:0];
          und_model = und_model | empty_prev;
          exp_q.push_back(pix_expect(wp[31:16], wp[15:0], empty_prev, und_model, pix_idx));
          pix_idx++;
        end
        if (oFrameStart) pix_idx = 0;
        req_prev = rd_if.rd_req;
        rd_if.rd_empty = inject_en && rd_if.rd_req && (pix_idx == INJ_IDX);
        if (rd_if.rd_empty) inject_en = 1'b0;
        empty_prev = rd_if.rd_empty;
      end
    end
  end

  // Monitor + scoreboard consumer.
  initial begin : monitor
    logic [56:0] exp;
    forever begin
      @(negedge iClk);
      cyc++;
      if (oFrameStart === 1'b1) begin
        fs_cnt++;
        prev_fs_cyc = last_fs_cyc;
        last_fs_cyc = cyc;
        first_req_cyc = 0;
        first_de_cyc = 0;
      end
      if (rd_if.rd_req === 1'b1) begin
        req_cnt++;
        if (first_req_cyc == 0) first_req_cyc = cyc;
      end
      if (oHS === 1'b0) hs_low++;
      if (oVS === 1'b0) vs_low++;
      if (oDE === 1'b1) begin
        de_cnt++;
        if (first_de_cyc == 0) begin
          first_de_cyc = cyc;
          first_pix = {oLCD_R, oLCD_G, oLCD_B, oX, oY};
        end
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $error("FAIL pixel_unexpected observed x=%0d y=%0d expected no pixel", oX, oY);
        end else begin
          exp = exp_q.pop_front();
          assert ({oUnderflow, oLCD_R, oLCD_G, oLCD_B, oX, oY} === exp) else begin
            failed++;
            $error("FAIL pixel observed=%0h expected=%0h",
                   {oUnderflow, oLCD_R, oLCD_G, oLCD_B, oX, oY}, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s_req, s_de, s_hs, s_vs, s_fs, en_cyc, rel_cyc;
    iRst_n = 1'b0;
    iEnable = 1'b0;

    // 1. Reset held, then released with iEnable low.
    tick(5);
    check("rst_syncs", {oHS, oVS}, 2'b11);
    check("rst_de_req_fs", {oDE, rd_if.rd_req, oFrameStart, oUnderflow}, 4'b0000);
    check("rst_rgb_xy", {oLCD_R, oLCD_G, oLCD_B, oX, oY}, 56'h0);
    iRst_n = 1'b1;
    tick(20);
    check("idle_no_fs", fs_cnt, 0);
    check("idle_no_req", req_cnt, 0);
    check("idle_outputs", {oHS, oVS, oDE}, 3'b110);

    // 2-4. First frame: timing, first pixel, underflow on pixel (5,2).
    inject_en = 1'b1;
    iEnable = 1'b1;
    en_cyc = cyc;
    wait_fs(10, "fs_first");
    check("fs_after_enable", last_fs_cyc - en_cyc, 1);
    s_req = req_cnt; s_de = de_cnt; s_hs = hs_low; s_vs = vs_low;
    tick(60);
    check("first_req_offset", first_req_cyc - last_fs_cyc, (VS + VB) * HT + HS + HB + 1);
    check("req_to_de", first_de_cyc - first_req_cyc, 2);
    check("first_pixel", first_pix, {8'hFF, 8'hF8, 8'hFF, 16'd0, 16'd0});
    wait_fs(200, "fs_second");
    check("frame1_period", last_fs_cyc - prev_fs_cyc, HT * VT);
    check("frame1_reqs", req_cnt - s_req, HA * VA);
    check("frame1_de", de_cnt - s_de, HA * VA);
    check("frame1_hs_low", hs_low - s_hs, HS * VT);
    check("frame1_vs_low", vs_low - s_vs, VS * HT);
    check("underflow_sticky", oUnderflow, 1'b1);

    // 5. Drop iEnable mid-frame: the frame completes, then the block idles.
    s_req = req_cnt; s_de = de_cnt; s_fs = fs_cnt;
    tick(40);
    iEnable = 1'b0;
    tick(300);
    check("stop_no_fs", fs_cnt, s_fs);
    check("stop_frame_reqs", req_cnt - s_req, HA * VA);
    check("stop_frame_de", de_cnt - s_de, HA * VA);
    check("stop_idle_syncs", {oHS, oVS, oDE, rd_if.rd_req}, 4'b1100);
    check("stop_xy_hold", {oX, oY}, {16'(HA - 1), 16'(VA - 1)});
    check("stop_underflow_kept", oUnderflow, 1'b1);

    // 6. One-cycle reset mid-active, then restart.
    iEnable = 1'b1;
    wait_fs(10, "fs_restart");
    tick(4 * HT + 8);
    iRst_n = 1'b0;
    tick(1);
    check("midrst_syncs", {oHS, oVS}, 2'b11);
    check("midrst_ctrl", {oDE, rd_if.rd_req, oFrameStart, oUnderflow}, 4'b0000);
    check("midrst_rgb_xy", {oLCD_R, oLCD_G, oLCD_B, oX, oY}, 56'h0);
    iRst_n = 1'b1;
    exp_q.delete();
    rel_cyc = cyc;
    wait_fs(10, "fs_after_rst");
    check("fs_after_rst_cycle", last_fs_cyc - rel_cyc, 1);
    s_de = de_cnt;
    wait_fs(200, "fs_after_rst_next");
    check("rst_frame_period", last_fs_cyc - prev_fs_cyc, HT * VT);
    check("rst_frame_de", de_cnt - s_de, HA * VA);
    iEnable = 1'b0;
    tick(150);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
